vga_timing_pipe: RTL and testbench

//  Parametrised VGA timing generator with built-in pixel-clock divider and aligned RGB output.

---
 rtl/vga_timing_pipe.sv | 156 +++++++++++++++
 tb/tb_vga_timing_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator: pixel-clock divider, h/v counters, sync decode and a
// latency-matched RGB/sync output register aligned to an external pixel source.
module vga_timing_pipe #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned COLOR_W  = 4,
   parameter int unsigned PIPE     = 1,
   parameter int unsigned CW       = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
   output logic [CW-1:0]      pix_x,
   output logic [CW-1:0]      pix_y,
   output logic               pix_req,
   output logic               pix_ce,
   output logic               line_start,
   output logic               frame_start,
   output logic [COLOR_W-1:0] vgaRed,
   output logic [COLOR_W-1:0] vgaGreen,
   output logic [COLOR_W-1:0] vgaBlue,
   output logic               Hsync,
   output logic               Vsync
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_pipe: CLK_DIV must be >= 1");
   end
   if (PIPE > 4) begin : g_bad_pipe
      $error("vga_timing_pipe: PIPE must be 0..4");
   end
   if ((H_TOTAL - 1) >= (64'd1 << CW) || (V_TOTAL - 1) >= (64'd1 << CW)) begin : g_bad_cw
      $error("vga_timing_pipe: CW too narrow for H_TOTAL/V_TOTAL");
   end

   logic [DW-1:0] r_div_cnt;
   logic [CW-1:0] r_h_cnt;
   logic [CW-1:0] r_v_cnt;
   logic          w_pix_ce;
   logic [2:0]    w_stg0;   // {act, hs, vs} decoded from the current counters
   logic [2:0]    w_stg_d;  // same, PIPE ticks later

   // Gated by rst/enable so a CLK_DIV=1 divider does not tick while held.
   assign w_pix_ce = enable & ~rst & (r_div_cnt == DW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_h_cnt   <= '0;
         r_v_cnt   <= '0;
      end else if (!enable) begin
         r_div_cnt <= '0;
         r_h_cnt   <= '0;
         r_v_cnt   <= '0;
      end else begin
         r_div_cnt <= w_pix_ce ? '0 : r_div_cnt + DW'(1);
         if (w_pix_ce) begin
            if (r_h_cnt == CW'(H_TOTAL - 1)) begin
               r_h_cnt <= '0;
               r_v_cnt <= (r_v_cnt == CW'(V_TOTAL - 1)) ? '0 : r_v_cnt + CW'(1);
            end else begin
               r_h_cnt <= r_h_cnt + CW'(1);
            end
         end
      end
   end

   always_comb begin
      w_stg0    = '0;
      w_stg0[2] = (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
      w_stg0[1] = (32'(r_h_cnt) >= HS_START) && (32'(r_h_cnt) < HS_END);
      w_stg0[0] = (32'(r_v_cnt) >= VS_START) && (32'(r_v_cnt) < VS_END);
   end

   // Delay line matches decode latency to the pixel-source latency.
   if (PIPE == 0) begin : g_nodly
      assign w_stg_d = w_stg0;
   end else begin : g_dly
      logic [2:0] r_dly [PIPE];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < int'(PIPE); i++) r_dly[i] <= '0;
         end else if (!enable) begin
            for (int i = 0; i < int'(PIPE); i++) r_dly[i] <= '0;
         end else if (w_pix_ce) begin
            r_dly[0] <= w_stg0;
            for (int i = 1; i < int'(PIPE); i++) r_dly[i] <= r_dly[i-1];
         end
      end

      assign w_stg_d = r_dly[PIPE-1];
   end

   logic [COLOR_W-1:0] r_red;
   logic [COLOR_W-1:0] r_green;
   logic [COLOR_W-1:0] r_blue;
   logic               r_hsync;
   logic               r_vsync;

   // Pin register loads only on pixel ticks so pins never change mid-pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
         r_hsync <= ~HS_POL;
         r_vsync <= ~VS_POL;
      end else if (!enable) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
         r_hsync <= ~HS_POL;
         r_vsync <= ~VS_POL;
      end else if (w_pix_ce) begin
         r_red   <= w_stg_d[2] ? pix_r : '0;
         r_green <= w_stg_d[2] ? pix_g : '0;
         r_blue  <= w_stg_d[2] ? pix_b : '0;
         r_hsync <= w_stg_d[1] ? HS_POL : ~HS_POL;
         r_vsync <= w_stg_d[0] ? VS_POL : ~VS_POL;
      end
   end

   assign pix_x       = r_h_cnt;
   assign pix_y       = r_v_cnt;
   assign pix_req     = w_stg0[2];
   assign pix_ce      = w_pix_ce;
   assign line_start  = w_pix_ce && (r_h_cnt == '0);
   assign frame_start = w_pix_ce && (r_h_cnt == '0) && (r_v_cnt == '0);
   assign vgaRed      = r_red;
   assign vgaGreen    = r_green;
   assign vgaBlue     = r_blue;
   assign Hsync       = r_hsync;
   assign Vsync       = r_vsync;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: two small-geometry instances (divided/PIPE=2/active-high sync and
// undivided/PIPE=0/active-low sync) compared cycle by cycle against a timeline model.
module tb_vga_timing_pipe;

   // Geometry shared by both instances: H 8/1/2/1 (12), V 4/1/1/1 (7)
   localparam int HT = 12;
   localparam int VT = 7;

   logic clk;
   logic rst;
   logic enable;

   logic [3:0] r_a, g_a, b_a, x_a, y_a, red_a, grn_a, blu_a;
   logic       req_a, ce_a, ls_a, fs_a, hs_a, vs_a;
   logic [3:0] r_b, g_b, b_b, x_b, y_b, red_b, grn_b, blu_b;
   logic       req_b, ce_b, ls_b, fs_b, hs_b, vs_b;

   int n_chk;
   int n_pass;
   int c;

   vga_timing_pipe #(
      .CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .PIPE(2), .CW(4)
   ) u_dut_a (
      .clk(clk), .rst(rst), .enable(enable),
      .pix_r(r_a), .pix_g(g_a), .pix_b(b_a),
      .pix_x(x_a), .pix_y(y_a), .pix_req(req_a), .pix_ce(ce_a),
      .line_start(ls_a), .frame_start(fs_a),
      .vgaRed(red_a), .vgaGreen(grn_a), .vgaBlue(blu_a),
      .Hsync(hs_a), .Vsync(vs_a)
   );

   vga_timing_pipe #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .PIPE(0), .CW(4)
   ) u_dut_b (
      .clk(clk), .rst(rst), .enable(enable),
      .pix_r(r_b), .pix_g(g_b), .pix_b(b_b),
      .pix_x(x_b), .pix_y(y_b), .pix_req(req_b), .pix_ce(ce_b),
      .line_start(ls_b), .frame_start(fs_b),
      .vgaRed(red_b), .vgaGreen(grn_b), .vgaBlue(blu_b),
      .Hsync(hs_b), .Vsync(vs_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Source A returns x two pixel ticks late; source B answers in the same tick.
   logic [3:0] src_d0, src_d1;
   always @(posedge clk) begin
      if (ce_a) begin
         src_d0 <= x_a;
         src_d1 <= src_d0;
      end
   end
   assign r_a = src_d1;
   assign g_a = 4'h5;
   assign b_a = 4'hC;
   assign r_b = x_b;
   assign g_b = y_b;
   assign b_b = 4'h9;

   task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Expected {x,y,req,ce,ls,fs,r,g,b,hsync,vsync} during cycle c after release.
   function automatic logic [25:0] exp_vec(int cy, int d, int p, bit hp, bit vp, bit is_b);
      int t, h, v, s, sh, sv;
      logic ce, act, hsy, vsy;
      logic [3:0] r, g, b;
      t  = cy / d;
      h  = t % HT;
      v  = (t / HT) % VT;
      ce = ((cy % d) == d - 1);
      s  = t - 1 - p;
      r = 4'd0; g = 4'd0; b = 4'd0; hsy = ~hp; vsy = ~vp;
      if (s >= 0) begin
         sh  = s % HT;
         sv  = (s / HT) % VT;
         act = (sh < 8) && (sv < 4);
         if (act) begin
            r = 4'(sh);
            g = is_b ? 4'(sv) : 4'h5;
            b = is_b ? 4'h9 : 4'hC;
         end
         if (sh >= 9 && sh < 11) hsy = hp;
         if (sv == 5) vsy = vp;
      end
      return {4'(h), 4'(v), (h < 8) && (v < 4), ce, ce && (h == 0), ce && (h == 0) && (v == 0),
              r, g, b, hsy, vsy};
   endfunction

   function automatic logic [25:0] reset_vec(bit hp, bit vp);
      return {4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, ~hp, ~vp};
   endfunction

   function automatic logic [25:0] obs_a();
      return {x_a, y_a, req_a, ce_a, ls_a, fs_a, red_a, grn_a, blu_a, hs_a, vs_a};
   endfunction

   function automatic logic [25:0] obs_b();
      return {x_b, y_b, req_b, ce_b, ls_b, fs_b, red_b, grn_b, blu_b, hs_b, vs_b};
   endfunction

   task automatic check_reset(input string tag);
      check({tag, " A"}, obs_a(), reset_vec(1'b1, 1'b1));
      check({tag, " B"}, obs_b(), reset_vec(1'b0, 1'b0));
   endtask

   // Run n cycles from posedge+1, comparing at each negedge; c counts cycles since release.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check($sformatf("A c%0d", c), obs_a(), exp_vec(c, 2, 2, 1'b1, 1'b1, 1'b0));
         check($sformatf("B c%0d", c), obs_b(), exp_vec(c, 1, 0, 1'b0, 1'b0, 1'b1));
         // Hand-derived spot values
         if (c == 2)  check("B red x1",        26'(red_b), 26'(4'd1));
         if (c == 10) check("B hsync low c10", 26'(hs_b),  26'(1'b0));
         if (c == 11) check("B hsync low c11", 26'(hs_b),  26'(1'b0));
         if (c == 12) check("B hsync idle c12", 26'(hs_b), 26'(1'b1));
         if (c == 84) check("B frame_start 84", 26'(fs_b), 26'(1'b1));
         if (c == 9)  check("A red x1",        26'(red_a), 26'(4'd1));
         if (c == 23) check("A hsync idle c23", 26'(hs_a), 26'(1'b0));
         if (c == 24) check("A hsync act c24", 26'(hs_a), 26'(1'b1));
         if (c == 27) check("A hsync act c27", 26'(hs_a), 26'(1'b1));
         if (c == 28) check("A hsync idle c28", 26'(hs_a), 26'(1'b0));
         if (c == 1)  check("A frame_start c1", 26'(fs_a), 26'(1'b1));
         @(posedge clk);
         #1;
         c++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_pass = 0;
      c      = 0;
      rst    = 1'b1;
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset("power-on reset");

      // Free run, several frames
      rst = 1'b0;
      c   = 0;
      run(400);

      // Async reset mid-frame takes effect before any clock edge
      rst = 1'b1;
      #1;
      check_reset("async reset immediate");
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset held");
      rst = 1'b0;
      c   = 0;
      run(230);

      // Enable drop clears at the next edge
      enable = 1'b0;
      @(posedge clk);
      #1;
      check_reset("enable low edge");
      repeat (2) @(posedge clk);
      #1;
      check_reset("enable low held");
      enable = 1'b1;
      c      = 0;
      run(200);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
